gs_sequencer: RTL

Unified start/done controller that sequences the shared Goldschmidt multiply datapath (goldschmidt, SIZE = LEADS+WIDTH) for both division and square root. Accepts a one-cycle start with an op code, latches it, and drives the operand selects, register enables and cloneA for the full iteration schedule. Signals done when the datapath result and r_sign are valid. Replaces free-running per-op control with a single handshaked sequencer.

---
 rtl/gs_pkg.sv | 43 ++++
 rtl/gs_schedule.sv | 58 +++++
 rtl/gs_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/gs_pkg.sv
// Shared types and constants for the Goldschmidt divide/sqrt sequencer.
package gs_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_SQRT = 2'b01
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DIV_STEPS_DEF  = 12;
  localparam int SQRT_STEPS_DEF = 16;

  // Operand A select encodings
  localparam logic [1:0] SA_K0 = 2'b00;
  localparam logic [1:0] SA_K  = 2'b01;
  localparam logic [1:0] SA_N  = 2'b10;

  // Operand B select encodings
  localparam logic [1:0] SB_N0 = 2'b00;
  localparam logic [1:0] SB_D0 = 2'b01;
  localparam logic [1:0] SB_N  = 2'b10;
  localparam logic [1:0] SB_D  = 2'b11;

  typedef struct packed {
    logic [1:0] sa;
    logic [1:0] sb;
    logic       en_n;
    logic       en_d;
    logic       en_k;
    logic       en_qd;
    logic       clone_a;
  } ctrl_t;

  function automatic logic is_sqrt(input logic [1:0] op);
    return op != OP_DIV;
  endfunction

endpackage

// File: rtl/gs_schedule.sv
// Combinational iteration schedule: maps (op, step) to datapath selects and enables.
module gs_schedule
  import gs_pkg::*;
(
  input  logic [1:0] op,
  input  logic [3:0] step,
  output ctrl_t      ctrl
);

  logic       stage;
  logic       mode;
  logic       rem;
  logic [3:0] mod3;

  assign stage = step[0];
  assign mode  = (step >= 4'd2) && (step <= 4'd10);
  assign rem   = (step == 4'd11);
  assign mod3  = step % 4'd3;

  always_comb begin
    ctrl = '0;
    if (!is_sqrt(op)) begin
      ctrl.sa    = {rem, mode};
      ctrl.sb    = {mode, stage};
      ctrl.en_n  = ~stage;
      ctrl.en_d  = stage;
      ctrl.en_k  = stage;
      ctrl.en_qd = rem;
    end else begin
      // Enables follow a period-3 N / K / D+K rhythm across all steps
      ctrl.en_n = (mod3 == 4'd0);
      ctrl.en_k = (mod3 != 4'd0);
      ctrl.en_d = (mod3 == 4'd2);
      case (step)
        4'd0, 4'd1: begin
          ctrl.clone_a = 1'b1;
          ctrl.sa      = SA_K0;
          ctrl.sb      = SB_N0;
        end
        4'd2: begin
          ctrl.sa = SA_K;
          ctrl.sb = SB_N0;
        end
        4'd3: begin
          ctrl.sa = SA_K;
          ctrl.sb = SB_N;
        end
        default: begin
          // From step 4 the clone/d/n period lines up with step mod 3 = 1/2/0
          ctrl.sa      = SA_K;
          ctrl.clone_a = (mod3 == 4'd1);
          ctrl.sb      = (mod3 == 4'd2) ? SB_D : (mod3 == 4'd0) ? SB_N : SB_N0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gs_sequencer.sv
// Start/done sequencer driving the shared Goldschmidt datapath for divide and sqrt.
module gs_sequencer
  import gs_pkg::*;
#(
  parameter int DIV_STEPS  = DIV_STEPS_DEF,
  parameter int SQRT_STEPS = SQRT_STEPS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op_in,
  input  logic       flush,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] op,
  output logic [1:0] sA,
  output logic [1:0] sB,
  output logic       enableN,
  output logic       enableD,
  output logic       enableK,
  output logic       enableQD,
  output logic       cloneA,
  output logic [3:0] step
);

  localparam logic [3:0] DIV_LAST  = 4'(DIV_STEPS - 1);
  localparam logic [3:0] SQRT_LAST = 4'(SQRT_STEPS - 1);

  state_t     state;
  ctrl_t      sched;
  ctrl_t      ctrl_gated;
  logic [3:0] last_step;

  assign last_step = is_sqrt(op) ? SQRT_LAST : DIV_LAST;

  gs_schedule u_schedule (
    .op   (op),
    .step (step),
    .ctrl (sched)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      step  <= 4'd0;
      op    <= OP_DIV;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (flush) begin
      state <= ST_IDLE;
      step  <= 4'd0;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (step == last_step) begin
            state <= ST_DONE;
            step  <= 4'd0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            step <= step + 4'd1;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE falls back to IDLE otherwise
          if (start) begin
            state <= ST_RUN;
            op    <= op_in;
            step  <= 4'd0;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
          done <= 1'b0;
        end
      endcase
    end
  end

  // Gating on the registered state zeroes controls the instant reset hits
  assign ctrl_gated = (state == ST_RUN) ? sched : '0;
  assign sA         = ctrl_gated.sa;
  assign sB         = ctrl_gated.sb;
  assign enableN    = ctrl_gated.en_n;
  assign enableD    = ctrl_gated.en_d;
  assign enableK    = ctrl_gated.en_k;
  assign enableQD   = ctrl_gated.en_qd;
  assign cloneA     = ctrl_gated.clone_a;

endmodule
